calc_entry_ctrl: RTL and testbench

- Writer side of the calculator screen interface: produces the cursor position `POS` and the 10-digit buffer `numeros` that the VGA display renders.
- Debounces five push-buttons and moves a cursor over a ROWS×COLS on-screen keypad.
- On ENTER, the key under the cursor edits the digit buffer or issues an operator to the ALU through a valid/ready handshake.
- Sits between the board buttons and the display/ALU, in the same `CLK` domain as the VGA controller.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/calc_entry_ctrl_btn_debounce.sv | 49 ++++
 rtl/calc_entry_ctrl.sv | 129 ++++++++++++
 tb/tb_calc_entry_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calculator keypad entry controller:
// key map, operator codes and button indices.
package calc_pkg;

    localparam logic [3:0] BLANK = 4'hF;

    localparam int KEY_CLR  = 10;
    localparam int KEY_BKSP = 11;
    localparam int KEY_OP0  = 12;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

    localparam int NBTN = 5;

    typedef enum logic [2:0] {
        B_UP,
        B_DOWN,
        B_LEFT,
        B_RIGHT,
        B_ENTER
    } btn_e;

endpackage

// File: rtl/calc_entry_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter,
// and a one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          s1_q, s2_q;
    logic          stab_q, stab_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stab_d = stab_q;
        cnt_d  = '0;
        if (s2_q != stab_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                stab_d = ~stab_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            stab_q <= 1'b0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= btn_i;
            s2_q   <= s1_q;
            stab_q <= stab_d;
            prev_q <= stab_q;
            cnt_q  <= cnt_d;
        end
    end

    assign press_o = stab_q & ~prev_q;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad entry controller: cursor navigation over the on-screen keypad,
// digit buffer editing and operator issue to the ALU.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int COLS       = 4,
    parameter int ROWS       = 5,
    parameter int NDIG       = 10,
    parameter int DEB_CYCLES = 250000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              BTN_UP,
    input  logic              BTN_DOWN,
    input  logic              BTN_LEFT,
    input  logic              BTN_RIGHT,
    input  logic              BTN_ENTER,
    output logic [4:0]        POS,
    output logic [4*NDIG-1:0] numeros,
    output logic [3:0]        DIGIT_COUNT,
    output logic              FULL,
    output logic              OP_VALID,
    output logic [2:0]        OP_CODE,
    input  logic              OP_READY
);

    logic [NBTN-1:0] raw, press;

    assign raw = {BTN_ENTER, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP};

    for (genvar i = 0; i < NBTN; i++) begin : g_deb
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk     (CLK),
            .rst     (RESET),
            .btn_i   (raw[i]),
            .press_o (press[i])
        );
    end

    logic [4:0]        pos_q, pos_d;
    logic [4*NDIG-1:0] num_q, num_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              full_q, full_d;
    logic              opv_q, opv_d;
    logic [2:0]        opc_q, opc_d;
    int                row, col, key;

    always_comb begin
        pos_d  = pos_q;
        num_d  = num_q;
        cnt_d  = cnt_q;
        full_d = 1'b0;
        opv_d  = opv_q;
        opc_d  = opc_q;
        key    = int'(pos_q);
        row    = key / COLS;
        col    = key % COLS;

        // Operand is consumed together with the operator
        if (opv_q && OP_READY) begin
            opv_d = 1'b0;
            num_d = {NDIG{BLANK}};
            cnt_d = '0;
        end

        if (press[B_ENTER]) begin
            if (!opv_q) begin
                unique case (1'b1)
                    (key < KEY_CLR): begin
                        if (cnt_q < 4'(NDIG)) begin
                            num_d = {num_q[4*NDIG-5:0], pos_q[3:0]};
                            cnt_d = cnt_q + 4'd1;
                        end else begin
                            full_d = 1'b1;
                        end
                    end
                    (key == KEY_CLR): begin
                        num_d = {NDIG{BLANK}};
                        cnt_d = '0;
                    end
                    (key == KEY_BKSP): begin
                        if (cnt_q != 4'd0) begin
                            num_d = {BLANK, num_q[4*NDIG-1:4]};
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    default: begin
                        opv_d = 1'b1;
                        opc_d = 3'(key - KEY_OP0);
                    end
                endcase
            end
        end else if (press[B_UP]) begin
            pos_d = 5'(((row == 0) ? ROWS - 1 : row - 1) * COLS + col);
        end else if (press[B_DOWN]) begin
            pos_d = 5'(((row == ROWS - 1) ? 0 : row + 1) * COLS + col);
        end else if (press[B_LEFT]) begin
            pos_d = 5'(row * COLS + ((col == 0) ? COLS - 1 : col - 1));
        end else if (press[B_RIGHT]) begin
            pos_d = 5'(row * COLS + ((col == COLS - 1) ? 0 : col + 1));
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pos_q  <= '0;
            num_q  <= {NDIG{BLANK}};
            cnt_q  <= '0;
            full_q <= 1'b0;
            opv_q  <= 1'b0;
            opc_q  <= '0;
        end else begin
            pos_q  <= pos_d;
            num_q  <= num_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            opv_q  <= opv_d;
            opc_q  <= opc_d;
        end
    end

    assign POS         = pos_q;
    assign numeros     = num_q;
    assign DIGIT_COUNT = cnt_q;
    assign FULL        = full_q;
    assign OP_VALID    = opv_q;
    assign OP_CODE     = opc_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Self-checking bench for calc_entry_ctrl against a keypad/digit-list
// reference model, with directed scenarios and randomized button traffic.
module tb_calc_entry_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_ENTER;
    logic        OP_READY;
    logic [4:0]  POS;
    logic [39:0] numeros;
    logic [3:0]  DIGIT_COUNT;
    logic        FULL, OP_VALID;
    logic [2:0]  OP_CODE;

    calc_entry_ctrl #(
        .COLS(4), .ROWS(5), .NDIG(10), .DEB_CYCLES(4)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN),
        .BTN_LEFT(BTN_LEFT), .BTN_RIGHT(BTN_RIGHT),
        .BTN_ENTER(BTN_ENTER),
        .POS(POS), .numeros(numeros), .DIGIT_COUNT(DIGIT_COUNT),
        .FULL(FULL), .OP_VALID(OP_VALID), .OP_CODE(OP_CODE),
        .OP_READY(OP_READY)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int full_seen = 0;
    int full_exp = 0;

    always @(negedge CLK) if (FULL === 1'b1) full_seen++;

    // Reference model: cursor as row/col, digits as a list (newest last)
    int m_r, m_c, m_opv, m_opc;
    int digs[$];

    function automatic void model_reset();
        m_r = 0; m_c = 0; m_opv = 0; m_opc = 0;
        digs.delete();
    endfunction

    function automatic logic [52:0] exp_vec();
        logic [39:0] n;
        int sz;
        n = '1;
        sz = digs.size();
        for (int i = 0; i < sz; i++) n[4*i +: 4] = 4'(digs[sz-1-i]);
        return {5'(m_r * 4 + m_c), n, 4'(sz), 1'(m_opv), 3'(m_opc)};
    endfunction

    function automatic logic [52:0] dut_vec();
        return {POS, numeros, DIGIT_COUNT, OP_VALID, OP_CODE};
    endfunction

    function automatic void model_apply(input logic [4:0] m);
        int k;
        if (m[4]) begin
            if (m_opv == 0) begin
                k = m_r * 4 + m_c;
                if (k < 10) begin
                    if (digs.size() < 10) digs.push_back(k);
                    else full_exp++;
                end else if (k == 10) begin
                    digs.delete();
                end else if (k == 11) begin
                    if (digs.size() > 0) void'(digs.pop_back());
                end else begin
                    m_opv = 1;
                    m_opc = k - 12;
                end
            end
        end else if (m[0]) m_r = (m_r + 4) % 5;
        else if (m[1]) m_r = (m_r + 1) % 5;
        else if (m[2]) m_c = (m_c + 3) % 4;
        else if (m[3]) m_c = (m_c + 1) % 4;
    endfunction

    task automatic drive(input logic [4:0] m);
        {BTN_ENTER, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP} = m;
    endtask

    // mask bits: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 ENTER
    task automatic press(input logic [4:0] m, input int hold);
        @(negedge CLK);
        drive(m);
        repeat (hold) @(negedge CLK);
        drive(5'd0);
        repeat (12) @(negedge CLK);
        if (hold >= 8) model_apply(m);
    endtask

    task automatic goto_key(input int k);
        int guard;
        guard = 0;
        while ((m_r * 4 + m_c) != k && guard < 20) begin
            if (m_r != k / 4) press(5'b00010, 10);
            else press(5'b01000, 10);
            guard++;
        end
    endtask

    task automatic ready_pulse();
        @(negedge CLK);
        OP_READY = 1'b1;
        @(negedge CLK);
        OP_READY = 1'b0;
        if (m_opv != 0) begin
            m_opv = 0;
            digs.delete();
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        OP_READY = 1'b0;
        drive(5'd0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        @(negedge CLK);
        n_cmp++;
        if (dut_vec() !== {5'd0, {40{1'b1}}, 4'd0, 1'b0, 3'd0} || FULL !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state got %h full %b want %h full 0",
                     dut_vec(), FULL, exp_vec());
        end
    endtask

    task automatic test_debounce();
        press(5'b01000, 20);
        n_cmp++;
        if (POS !== 5'd1) begin
            n_bad++;
            $display("FAIL hold_right got POS %0d want 1", POS);
        end
        press(5'b00001, 2);
        n_cmp++;
        if (POS !== 5'd1) begin
            n_bad++;
            $display("FAIL glitch_up got POS %0d want 1", POS);
        end
    endtask

    task automatic test_nav();
        logic [4:0] want[3];
        logic [4:0] m[3];
        press(5'b00100, 10);
        want = '{5'd3, 5'd19, 5'd3};
        m    = '{5'b00100, 5'b00001, 5'b00010};
        for (int i = 0; i < 3; i++) begin
            press(m[i], 10);
            n_cmp++;
            if (POS !== want[i] || dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL nav_wrap%0d got POS %0d want %0d", i, POS, want[i]);
            end
        end
    endtask

    task automatic test_digits();
        goto_key(7);  press(5'b10000, 10);
        goto_key(2);  press(5'b10000, 10);
        n_cmp++;
        if (numeros !== {32'hFFFF_FFFF, 8'h72} || DIGIT_COUNT !== 4'd2) begin
            n_bad++;
            $display("FAIL digits_72 got %h cnt %0d want ffffffff72 cnt 2",
                     numeros, DIGIT_COUNT);
        end
        goto_key(11); press(5'b10000, 10);
        n_cmp++;
        if (numeros[3:0] !== 4'h7 || DIGIT_COUNT !== 4'd1) begin
            n_bad++;
            $display("FAIL bksp_one got %h cnt %0d want digit 7 cnt 1",
                     numeros, DIGIT_COUNT);
        end
        press(5'b10000, 10);
        press(5'b10000, 10);
        n_cmp++;
        if (numeros !== {40{1'b1}} || DIGIT_COUNT !== 4'd0) begin
            n_bad++;
            $display("FAIL bksp_empty got %h cnt %0d want all F cnt 0",
                     numeros, DIGIT_COUNT);
        end
    endtask

    task automatic test_full();
        int f0;
        for (int i = 0; i < 10; i++) begin
            goto_key(int'($urandom_range(0, 9)));
            press(5'b10000, 10);
        end
        f0 = full_seen;
        press(5'b10000, 10);
        n_cmp++;
        if (full_seen - f0 !== 1 || DIGIT_COUNT !== 4'd10 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL overflow got pulses %0d cnt %0d state %h want 1 10 %h",
                     full_seen - f0, DIGIT_COUNT, dut_vec(), exp_vec());
        end
        goto_key(10); press(5'b10000, 10);
        n_cmp++;
        if (numeros !== {40{1'b1}} || DIGIT_COUNT !== 4'd0) begin
            n_bad++;
            $display("FAIL clear got %h cnt %0d want all F 0", numeros, DIGIT_COUNT);
        end
    endtask

    task automatic test_op();
        goto_key(3);  press(5'b10000, 10);
        goto_key(13); press(5'b10000, 10);
        n_cmp++;
        if (OP_VALID !== 1'b1 || OP_CODE !== 3'd1 || numeros[3:0] !== 4'h3) begin
            n_bad++;
            $display("FAIL op_issue got v %b code %0d num %h want 1 1 ..3",
                     OP_VALID, OP_CODE, numeros);
        end
        goto_key(4);  press(5'b10000, 10);
        n_cmp++;
        if (dut_vec() !== exp_vec() || DIGIT_COUNT !== 4'd1) begin
            n_bad++;
            $display("FAIL op_hold got %h want %h", dut_vec(), exp_vec());
        end
        ready_pulse();
        n_cmp++;
        if (OP_VALID !== 1'b0 || numeros !== {40{1'b1}} || DIGIT_COUNT !== 4'd0) begin
            n_bad++;
            $display("FAIL op_accept got v %b num %h cnt %0d want 0 all F 0",
                     OP_VALID, numeros, DIGIT_COUNT);
        end
    endtask

    task automatic test_back_to_back();
        goto_key(5);
        press(5'b11000, 10);
        n_cmp++;
        if (POS !== 5'd5 || numeros[3:0] !== 4'h5 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL enter_right got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_op();
        goto_key(12);
        press(5'b10000, 10);
        n_cmp++;
        if (OP_VALID !== 1'b1 || OP_CODE !== 3'd0) begin
            n_bad++;
            $display("FAIL op_pending got v %b code %0d want 1 0", OP_VALID, OP_CODE);
        end
        @(negedge CLK);
        #1 RESET = 1'b1;
        #1;
        n_cmp++;
        if (dut_vec() !== {5'd0, {40{1'b1}}, 4'd0, 1'b0, 3'd0} || FULL !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset got %h want 0/all F/0/0/0", dut_vec());
        end
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_random();
        int r;
        logic [4:0] m;
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                ready_pulse();
            end else begin
                if (r < 16) m = 5'($urandom_range(1, 31));
                else if (r < 36) m = 5'b10000;
                else m = 5'(1 << $urandom_range(0, 3));
                press(m, 10);
            end
            n_cmp++;
            if (dut_vec() !== exp_vec() || full_seen !== full_exp) begin
                n_bad++;
                $display("FAIL random%0d got %h full %0d want %h full %0d",
                         i, dut_vec(), full_seen, exp_vec(), full_exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_nav();
        test_digits();
        test_full();
        test_op();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
